// File: rtl/pc_fetch_control.sv
// pc_fetch_control: program-counter stage of the MIPS pipeline.
// Holds the PC and selects the next PC: halt, then branch, then stall, then
// jump, then PC+4. The debug unit sequences it through run, single-step and
// halt, and it counts retired fetches.
// Optional feature: define PC_CYCLE_COUNT_EN to add o_cycle_count, a count of
// every clock spent in RUN or STEP_WAIT, stalled cycles included.
module pc_fetch_control #(
   parameter int unsigned      NBITS    = 32,
   parameter logic [NBITS-1:0] RESET_PC = '0
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_enable,
   input  logic             i_step_mode,
   input  logic             i_step,
   input  logic             i_stall,
   input  logic             i_branch_taken,
   input  logic [NBITS-1:0] i_branch_target,
   input  logic             i_jump,
   input  logic [NBITS-1:0] i_jump_target,
   input  logic             i_halt_detect,
   output logic [NBITS-1:0] o_pc,
   output logic [NBITS-1:0] o_pc4,
   output logic             o_fetch_valid,
   output logic             o_halted,
   output logic [NBITS-1:0] o_instr_count
`ifdef PC_CYCLE_COUNT_EN
  ,output logic [NBITS-1:0] o_cycle_count
`endif
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_RUN       = 2'd1,
      S_STEP_WAIT = 2'd2,
      S_HALTED    = 2'd3
   } state_t;

   // Targets are word-aligned; the two low bits are cleared on load.
   localparam logic [NBITS-1:0] ALIGN_MASK = ~NBITS'(3);

   state_t           state_q, state_d;
   logic [NBITS-1:0] pc_q, pc_d;
   logic [NBITS-1:0] instr_count_q, instr_count_d;
   logic             halted_q, halted_d;
   logic             advance;
   logic             fetch_valid;
`ifdef PC_CYCLE_COUNT_EN
   logic [NBITS-1:0] cycle_count_q, cycle_count_d;
`endif

   // Sequencing and next-PC selection; an advancing cycle is any RUN cycle or
   // a STEP_WAIT cycle carrying an i_step pulse.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_count_d = instr_count_q;
      advance       = 1'b0;
      fetch_valid   = 1'b0;
`ifdef PC_CYCLE_COUNT_EN
      cycle_count_d = cycle_count_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (i_enable) begin
               state_d = i_step_mode ? S_STEP_WAIT : S_RUN;
            end
         end
         S_RUN:       advance = 1'b1;
         S_STEP_WAIT: advance = i_step;
         S_HALTED:    advance = 1'b0;
         default:     state_d = S_IDLE;
      endcase

`ifdef PC_CYCLE_COUNT_EN
      if (state_q == S_RUN || state_q == S_STEP_WAIT) begin
         cycle_count_d = cycle_count_q + NBITS'(1);
      end
`endif

      if (advance) begin
         fetch_valid = 1'b1;
         if (i_halt_detect) begin
            // PC stays on the HALT instruction, even with a redirect pending.
            state_d = S_HALTED;
         end else if (i_branch_taken) begin
            // A taken branch flushes and redirects even when a stall is raised.
            pc_d          = i_branch_target & ALIGN_MASK;
            instr_count_d = instr_count_q + NBITS'(1);
         end else if (i_stall) begin
            // Jump is dropped here; decode re-asserts it once the stall clears.
            fetch_valid = 1'b0;
         end else if (i_jump) begin
            pc_d          = i_jump_target & ALIGN_MASK;
            instr_count_d = instr_count_q + NBITS'(1);
         end else begin
            pc_d          = pc_q + NBITS'(4);
            instr_count_d = instr_count_q + NBITS'(1);
         end
      end

      halted_d = (state_d == S_HALTED);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q       <= S_IDLE;
         pc_q          <= RESET_PC;
         instr_count_q <= '0;
         halted_q      <= 1'b0;
`ifdef PC_CYCLE_COUNT_EN
         cycle_count_q <= '0;
`endif
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_count_q <= instr_count_d;
         halted_q      <= halted_d;
`ifdef PC_CYCLE_COUNT_EN
         cycle_count_q <= cycle_count_d;
`endif
      end
   end

   assign o_pc          = pc_q;
   assign o_pc4         = pc_q + NBITS'(4);
   assign o_fetch_valid = fetch_valid;
   assign o_halted      = halted_q;
   assign o_instr_count = instr_count_q;
`ifdef PC_CYCLE_COUNT_EN
   assign o_cycle_count = cycle_count_q;
`endif

endmodule

// File: tb/tb_pc_fetch_control.sv
// Scoreboard bench for pc_fetch_control: a behavioural model predicts each
// cycle's outputs, the driver queues them, and a monitor compares them.
module tb_pc_fetch_control;

   logic        clk = 1'b0;
   logic        rst, en, smode, step, stall, br, jmp, halt;
   logic [31:0] br_t, jmp_t;
   logic [31:0] pc, pc4, icnt;
   logic        fv, halted;
   logic [31:0] ccnt;

   int compared   = 0;
   int mismatched = 0;

   pc_fetch_control dut (
      .i_clk(clk), .i_reset(rst), .i_enable(en), .i_step_mode(smode),
      .i_step(step), .i_stall(stall), .i_branch_taken(br),
      .i_branch_target(br_t), .i_jump(jmp), .i_jump_target(jmp_t),
      .i_halt_detect(halt), .o_pc(pc), .o_pc4(pc4), .o_fetch_valid(fv),
      .o_halted(halted), .o_instr_count(icnt)
`ifdef PC_CYCLE_COUNT_EN
     ,.o_cycle_count(ccnt)
`endif
   );

`ifndef PC_CYCLE_COUNT_EN
   assign ccnt = '0;
`endif

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc, pc4, cnt, cyc;
      logic        fv, halted;
   } exp_t;
   exp_t q[$];

   // Model: mode 0 idle, 1 run, 2 single-step, 3 halted.
   int          m_mode;
   logic [31:0] m_pc, m_cnt, m_cyc;

   function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("FAIL %s: got %h required %h", name, got, want);
      end
   endfunction

   // Does this cycle move the pipeline, per the debug-unit mode?
   function automatic bit moving();
      return (m_mode == 1) || (m_mode == 2 && step);
   endfunction

   // Queue this cycle's expected outputs, then advance the model over the edge.
   task automatic tick();
      exp_t e;
      e.pc     = m_pc;
      e.pc4    = m_pc + 32'd4;
      e.cnt    = m_cnt;
      e.cyc    = m_cyc;
      e.halted = (m_mode == 3);
      e.fv     = moving() && (halt || br || !stall);
      q.push_back(e);
      if (rst) begin
         m_mode = 0; m_pc = 0; m_cnt = 0; m_cyc = 0;
      end else begin
         if (m_mode == 1 || m_mode == 2) m_cyc = m_cyc + 1;
         if (m_mode == 0) begin
            if (en) m_mode = smode ? 2 : 1;
         end else if (moving()) begin
            if (halt) m_mode = 3;
            else if (br) begin m_pc = {br_t[31:2], 2'b00}; m_cnt = m_cnt + 1; end
            else if (!stall) begin
               m_pc  = jmp ? {jmp_t[31:2], 2'b00} : m_pc + 32'd4;
               m_cnt = m_cnt + 1;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      rst = 0; en = 0; smode = 0; step = 0; stall = 0;
      br = 0; jmp = 0; halt = 0; br_t = 32'h0; jmp_t = 32'h0;
   endtask

   task automatic do_reset();
      quiet(); rst = 1; tick(); rst = 0;
   endtask

   // Monitor: compare outputs against the oldest queued expectation.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("pc", pc, e.pc);
         chk("pc4", pc4, e.pc4);
         chk("fetch_valid", 32'(fv), 32'(e.fv));
         chk("halted", 32'(halted), 32'(e.halted));
         chk("instr_count", icnt, e.cnt);
`ifdef PC_CYCLE_COUNT_EN
         chk("cycle_count", ccnt, e.cyc);
`endif
      end
   end

   initial begin
      quiet();
      rst = 1;
      @(posedge clk); #1;
      m_mode = 0; m_pc = 0; m_cnt = 0; m_cyc = 0;

      // Continuous run from reset.
      do_reset();
      en = 1; tick(); en = 0;
      repeat (4) tick();
      chk("run4_pc", pc, 32'h10);
      chk("run4_count", icnt, 32'd4);

      // Branch redirect beats a simultaneous stall.
      br = 1; br_t = 32'h40; stall = 1; tick(); quiet();
      chk("br_over_stall_pc", pc, 32'h40);
      chk("br_over_stall_count", icnt, 32'd5);

      // Stall suppresses a jump; jump alone then loads an aligned target.
      jmp = 1; jmp_t = 32'h20; tick();
      stall = 1; jmp_t = 32'h999; repeat (2) tick(); quiet();
      chk("stall_pc", pc, 32'h20);
      chk("stall_count", icnt, 32'd6);
      jmp = 1; jmp_t = 32'h103; tick(); quiet();
      chk("jump_align_pc", pc, 32'h100);

      // Halt wins over a branch; later inputs are ignored until reset.
      halt = 1; br = 1; br_t = 32'h200; tick(); quiet();
      chk("halted_flag", 32'(halted), 32'd1);
      jmp = 1; jmp_t = 32'h300; br = 1; br_t = 32'h400; en = 1; repeat (3) tick(); quiet();
      chk("halted_pc", pc, 32'h100);
      do_reset();
      chk("reset_pc", pc, 32'h0);
      chk("reset_halted", 32'(halted), 32'd0);

      // Single-step mode.
      en = 1; smode = 1; tick(); quiet();
      repeat (5) tick();
      chk("step_idle_pc", pc, 32'h0);
      repeat (3) begin step = 1; tick(); step = 0; tick(); end
      chk("step_pc", pc, 32'hC);
      chk("step_count", icnt, 32'd3);

      // Wrap at the top of the address space.
      do_reset();
      en = 1; tick(); quiet();
      jmp = 1; jmp_t = 32'hFFFF_FFFF; tick(); quiet();
      chk("wrap_pc4", pc4, 32'h0);
      tick();
      chk("wrap_pc", pc, 32'h0);

      // Randomized traffic, including occasional halt and reset.
      for (int i = 0; i < 3000; i++) begin
         rst   = ($urandom_range(0, 79) == 0);
         en    = ($urandom_range(0, 3) == 0);
         smode = $urandom_range(0, 1);
         step  = ($urandom_range(0, 2) == 0);
         stall = ($urandom_range(0, 3) == 0);
         br    = ($urandom_range(0, 5) == 0);
         jmp   = ($urandom_range(0, 5) == 0);
         halt  = ($urandom_range(0, 49) == 0);
         br_t  = $urandom;
         jmp_t = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC - 32'($urandom_range(0, 3)) : $urandom;
         tick();
      end
      quiet();

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
      #1;
      compared++;
      if (q.size() != 0) begin
         mismatched++;
         $display("FAIL drain: got %0d pending required 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
